// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch
// Purpose  : Instruction-fetch stage. Owns the PC, issues in-order word
//            fetches, queues {pc, inst} pairs in a 2-entry buffer toward
//            decode and drops stale responses after a redirect.
// Revision : 1.0 - initial release
// ============================================================================
module inst_fetch #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    INST_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h1c00_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  inst_req_valid,
    input  logic                  inst_req_ready,
    output logic [ADDR_WIDTH-1:0] inst_req_addr,
    input  logic                  inst_resp_valid,
    input  logic [INST_WIDTH-1:0] inst_resp_data,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  id_valid,
    input  logic                  id_ready,
    output logic [INST_WIDTH-1:0] id_inst,
    output logic [ADDR_WIDTH-1:0] id_pc
);

    localparam logic [0:0]            c_ST_FETCH   = 1'b0;
    localparam logic [0:0]            c_ST_DRAIN   = 1'b1;
    localparam logic [ADDR_WIDTH-1:0] c_PC_STEP    = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] c_ALIGN_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

    logic [0:0]            r_state;
    logic [0:0]            w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [1:0]            r_out_cnt;
    logic [1:0]            r_discard;
    logic [1:0]            r_q_cnt;
    logic [INST_WIDTH-1:0] r_q_inst [2];
    logic [ADDR_WIDTH-1:0] r_q_pc   [2];
    logic [ADDR_WIDTH-1:0] r_tag    [2];
    logic                  r_tag_wp;
    logic                  r_tag_rp;

    logic                  w_pop;
    logic                  w_credit;
    logic                  w_accept;
    logic                  w_push;
    logic [1:0]            w_out_nxt;
    logic [1:0]            w_discard_nxt;
    logic [1:0]            w_slot;

    assign inst_req_addr = r_pc;
    assign id_valid      = (r_q_cnt != 2'd0);
    assign id_inst       = r_q_inst[0];
    assign id_pc         = r_q_pc[0];

    // Credit, handshake qualifiers, counter updates and next-state selection.
    always_comb begin
        w_pop         = 1'b0;
        w_credit      = 1'b0;
        w_accept      = 1'b0;
        w_push        = 1'b0;
        w_out_nxt     = r_out_cnt;
        w_discard_nxt = r_discard;
        w_slot        = r_q_cnt;
        w_state_nxt   = r_state;
        inst_req_valid = 1'b0;

        w_pop = id_valid && id_ready;
        // A slot freed by this cycle's pop counts as credit; its response
        // can only land on a later edge, so out+count never exceeds 2.
        w_credit = (({1'b0, r_out_cnt} + {1'b0, r_q_cnt}) - {2'b00, w_pop}) < 3'd2;
        inst_req_valid = rst_n && (r_state == c_ST_FETCH) && w_credit;
        w_accept = inst_req_valid && inst_req_ready;

        // Responses are kept only with nothing stale pending and no redirect.
        w_push = inst_resp_valid && !redirect_valid && (r_discard == 2'd0);
        w_slot = r_q_cnt - {1'b0, w_pop};

        w_out_nxt = r_out_cnt + {1'b0, w_accept} - {1'b0, inst_resp_valid};

        if (redirect_valid) begin
            w_discard_nxt = w_out_nxt;
        end else if (inst_resp_valid && (r_discard != 2'd0)) begin
            w_discard_nxt = r_discard - 2'd1;
        end

        if (redirect_valid) begin
            w_state_nxt = (w_discard_nxt != 2'd0) ? c_ST_DRAIN : c_ST_FETCH;
        end else if ((r_state == c_ST_DRAIN) && (w_discard_nxt == 2'd0)) begin
            w_state_nxt = c_ST_FETCH;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_ST_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // PC, outstanding and discard bookkeeping; redirect overrides increment.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc      <= RESET_PC;
            r_out_cnt <= 2'd0;
            r_discard <= 2'd0;
        end else begin
            r_out_cnt <= w_out_nxt;
            r_discard <= w_discard_nxt;
            if (redirect_valid) begin
                r_pc <= redirect_pc & c_ALIGN_MASK;
            end else if (w_accept) begin
                r_pc <= r_pc + c_PC_STEP;
            end
        end
    end

    // In-order tag FIFO holding the PC of every accepted request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tag_wp <= 1'b0;
            r_tag_rp <= 1'b0;
            r_tag[0] <= '0;
            r_tag[1] <= '0;
        end else begin
            if (w_accept) begin
                r_tag[r_tag_wp] <= r_pc;
                r_tag_wp        <= ~r_tag_wp;
            end
            if (inst_resp_valid) begin
                r_tag_rp <= ~r_tag_rp;
            end
        end
    end

    // Two-entry output queue; entry 0 is the head seen by decode.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q_cnt     <= 2'd0;
            r_q_inst[0] <= '0;
            r_q_inst[1] <= '0;
            r_q_pc[0]   <= '0;
            r_q_pc[1]   <= '0;
        end else begin
            if (w_pop) begin
                r_q_inst[0] <= r_q_inst[1];
                r_q_pc[0]   <= r_q_pc[1];
            end
            // Write after the shift so a push into slot 0 wins over it.
            if (w_push) begin
                if (w_slot == 2'd0) begin
                    r_q_inst[0] <= inst_resp_data;
                    r_q_pc[0]   <= r_tag[r_tag_rp];
                end else begin
                    r_q_inst[1] <= inst_resp_data;
                    r_q_pc[1]   <= r_tag[r_tag_rp];
                end
            end
            if (redirect_valid) begin
                r_q_cnt <= 2'd0;
            end else begin
                r_q_cnt <= r_q_cnt + {1'b0, w_push} - {1'b0, w_pop};
            end
        end
    end

    a_out_max:     assert property (@(posedge clk) disable iff (!rst_n) r_out_cnt <= 2'd2);
    a_q_max:       assert property (@(posedge clk) disable iff (!rst_n) r_q_cnt <= 2'd2);
    a_discard_max: assert property (@(posedge clk) disable iff (!rst_n) r_discard <= r_out_cnt);
    a_resp_owed:   assert property (@(posedge clk) disable iff (!rst_n)
                                    inst_resp_valid |-> (r_out_cnt != 2'd0));

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_fetch
// Purpose  : Scoreboard bench for inst_fetch with an in-order memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_fetch;

    localparam logic [31:0] c_RESET_PC = 32'h1c00_0000;
    localparam logic [31:0] c_DATA_KEY = 32'h5a5a_c3c3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        inst_req_valid;
    logic        inst_req_ready = 1'b0;
    logic [31:0] inst_req_addr;
    logic        inst_resp_valid = 1'b0;
    logic [31:0] inst_resp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_inst;
    logic [31:0] id_pc;

    typedef struct { logic [31:0] addr; int due; int epoch; } pend_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;

    pend_t       pend_q[$];
    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          epoch = 0;
    int          mem_lat = 1;
    int          handshakes = 0;
    int          first_acc_cyc = -1;
    int          first_idv_cyc = -1;
    logic        redir_hit = 1'b0;
    logic        saw_zero = 1'b0;
    logic        rf_acc_pend = 1'b0;
    logic        rf_id_pend = 1'b0;
    logic [31:0] rf_acc_addr = '0;
    logic [31:0] rf_id_pc = '0;
    logic [31:0] exp_next = c_RESET_PC;
    logic        s_req_valid = 1'b0;
    logic        s_id_valid = 1'b0;
    logic [31:0] s_req_addr = '0;
    logic [31:0] stall_addr = '0;

    inst_fetch dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .inst_req_valid  (inst_req_valid),
        .inst_req_ready  (inst_req_ready),
        .inst_req_addr   (inst_req_addr),
        .inst_resp_valid (inst_resp_valid),
        .inst_resp_data  (inst_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .id_valid        (id_valid),
        .id_ready        (id_ready),
        .id_inst         (id_inst),
        .id_pc           (id_pc)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    // One clock cycle; entered and left at posedge+1.
    // rd_mode: 0 none, 1 redirect, 2 redirect only if resp and accept coincide.
    task automatic step(input logic rdy, input logic idr, input int rd_mode, input logic [31:0] rpc);
        pend_t p;
        exp_t  e;
        bit    stale;
        inst_req_ready = rdy;
        id_ready       = idr;
        redirect_pc    = rpc;
        redirect_valid = (rd_mode == 1);
        if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            inst_resp_valid = 1'b1;
            inst_resp_data  = pend_q[0].addr ^ c_DATA_KEY;
        end else begin
            inst_resp_valid = 1'b0;
            inst_resp_data  = '0;
        end
        #1;
        if (rd_mode == 2 && inst_resp_valid && inst_req_valid && inst_req_ready) begin
            redirect_valid = 1'b1;
            redir_hit      = 1'b1;
        end
        @(negedge clk);
        s_req_valid = inst_req_valid;
        s_req_addr  = inst_req_addr;
        s_id_valid  = id_valid;
        stale = 0;
        foreach (pend_q[i]) if (pend_q[i].epoch != epoch) stale = 1;
        if (stale) check("drain_no_req", 32'(inst_req_valid), 32'd0);
        if (id_valid && first_idv_cyc < 0) first_idv_cyc = cyc;
        if (id_valid && id_ready) begin
            handshakes++;
            check("id_sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("id_pc", id_pc, e.pc);
                check("id_inst", id_inst, e.inst);
            end
            if (rf_id_pend) begin
                rf_id_pc   = id_pc;
                rf_id_pend = 1'b0;
            end
        end
        if (redirect_valid) exp_q.delete();
        if (inst_resp_valid) begin
            p = pend_q.pop_front();
            if (p.epoch == epoch && !redirect_valid) begin
                e.pc   = p.addr;
                e.inst = p.addr ^ c_DATA_KEY;
                exp_q.push_back(e);
            end
        end
        if (inst_req_valid && inst_req_ready) begin
            check("req_addr", inst_req_addr, exp_next);
            if (first_acc_cyc < 0) first_acc_cyc = cyc;
            if (inst_req_addr == 32'd0) saw_zero = 1'b1;
            if (rf_acc_pend) begin
                rf_acc_addr = inst_req_addr;
                rf_acc_pend = 1'b0;
            end
            p.addr  = inst_req_addr;
            p.due   = cyc + mem_lat;
            p.epoch = epoch;
            pend_q.push_back(p);
            exp_next = exp_next + 32'd4;
        end
        if (redirect_valid) begin
            epoch++;
            exp_next    = redirect_pc & 32'hffff_fffc;
            rf_acc_pend = 1'b1;
            rf_id_pend  = 1'b1;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Memory side is reset together with the DUT, so all model state clears.
    task automatic do_reset();
        rst_n           = 1'b0;
        inst_req_ready  = 1'b0;
        inst_resp_valid = 1'b0;
        inst_resp_data  = '0;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        id_ready        = 1'b0;
        pend_q.delete();
        exp_q.delete();
        epoch       = 0;
        exp_next    = c_RESET_PC;
        rf_acc_pend = 1'b0;
        rf_id_pend  = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_id_valid", 32'(id_valid), 32'd0);
        check("rst_req_valid", 32'(inst_req_valid), 32'd0);
        check("rst_id_pc", id_pc, 32'd0);
        check("rst_id_inst", id_inst, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc++;
    endtask

    initial begin
        do_reset();

        // Streaming: latency 1, full-rate decode.
        step(1, 1, 0, 0);
        check("first_req_valid", 32'(s_req_valid), 32'd1);
        check("first_req_addr", s_req_addr, c_RESET_PC);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0);
        check("first_id_latency", 32'(first_idv_cyc - first_acc_cyc), 32'd2);
        handshakes = 0;
        for (int i = 0; i < 16; i++) step(1, 1, 0, 0);
        check("sustain_rate", 32'(handshakes), 32'd16);

        // Decode back-pressure fills the queue and stops requests.
        for (int i = 0; i < 10; i++) step(1, 0, 0, 0);
        check("bp_req_valid_off", 32'(s_req_valid), 32'd0);
        check("bp_id_valid", 32'(s_id_valid), 32'd1);
        for (int i = 0; i < 8; i++) step(1, 1, 0, 0);

        // Redirect with two requests in flight.
        mem_lat = 3;
        for (int i = 0; i < 20 && pend_q.size() != 2; i++) step(1, 1, 0, 0);
        check("wait_two_outstanding", 32'(pend_q.size()), 32'd2);
        step(1, 1, 1, 32'h1c00_0103);
        for (int i = 0; i < 12; i++) step(1, 1, 0, 0);
        check("redir_first_req", rf_acc_addr, 32'h1c00_0100);
        check("redir_first_id_pc", rf_id_pc, 32'h1c00_0100);

        // Redirect coinciding with a response and an acceptance.
        mem_lat = 1;
        for (int i = 0; i < 10; i++) step(1, 1, 0, 0);
        for (int i = 0; i < 10 && !redir_hit; i++) step(1, 1, 2, 32'h1c00_0300);
        check("coincident_redirect_seen", 32'(redir_hit), 32'd1);
        for (int i = 0; i < 10; i++) step(1, 1, 0, 0);
        check("coincident_first_id_pc", rf_id_pc, 32'h1c00_0300);

        // Memory stall, redirect during the stall, then PC wrap.
        step(0, 1, 0, 0);
        stall_addr = s_req_addr;
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
        check("stall_addr_stable", s_req_addr, stall_addr);
        check("stall_req_valid", 32'(s_req_valid), 32'd1);
        step(0, 1, 1, 32'h1c00_0200);
        step(0, 1, 0, 0);
        check("stall_redir_addr", s_req_addr, 32'h1c00_0200);
        check("stall_redir_valid", 32'(s_req_valid), 32'd1);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0);
        saw_zero = 1'b0;
        step(1, 1, 1, 32'hffff_fffc);
        for (int i = 0; i < 8; i++) step(1, 1, 0, 0);
        check("pc_wrap_zero", 32'(saw_zero), 32'd1);

        // Reset mid-operation with a full queue.
        for (int i = 0; i < 8; i++) step(1, 0, 0, 0);
        check("pre_reset_full", 32'(s_id_valid), 32'd1);
        do_reset();
        step(1, 1, 0, 0);
        check("post_reset_valid", 32'(s_req_valid), 32'd1);
        check("post_reset_addr", s_req_addr, c_RESET_PC);
        for (int i = 0; i < 6; i++) step(1, 1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
